// File: rtl/mux_response_scanner.sv
// Scans an external 16:1 mux: drives each select in turn, waits for the mux
// output to settle, samples it, and presents the 16 samples as one word.
module mux_response_scanner #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mux_in,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] resp,
  output logic        resp_valid,
  input  logic        resp_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  sel_reg, sel_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] shadow_reg, shadow_next;
  logic [15:0] resp_reg, resp_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= 4'd0;
      cnt_reg    <= 8'd0;
      shadow_reg <= 16'h0000;
      resp_reg   <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
      resp_reg   <= resp_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    resp_next   = resp_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = SETTLE;
          sel_next    = 4'd0;
          cnt_next    = CNT_LOAD;
          shadow_next = 16'h0000;
        end
      end
      SETTLE: begin
        if (cnt_reg == 8'd0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SAMPLE: begin
        shadow_next[sel_reg] = mux_in;
        // The final sample goes straight into resp along with the earlier ones.
        if (sel_reg == 4'd15) begin
          resp_next  = shadow_next;
          state_next = DONE;
        end else begin
          sel_next   = sel_reg + 4'd1;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
          sel_next   = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel        = sel_reg;
  assign busy       = (state_reg == SETTLE) || (state_reg == SAMPLE);
  assign resp_valid = (state_reg == DONE);
  assign resp       = resp_reg;

endmodule
